// File: rtl/hh_pkg.sv
// hh_pkg: shared constants, FSM state type and helpers for the HH membrane integrator
package hh_pkg;

    localparam int DW = 48;

    localparam logic signed [DW-1:0] GATE_SCALE = 1000;
    localparam logic signed [DW-1:0] G_NA       = 120;
    localparam logic signed [DW-1:0] G_K        = 36;
    localparam logic signed [DW-1:0] G_L_X10    = 3;
    localparam logic signed [DW-1:0] E_NA       = 500;
    localparam logic signed [DW-1:0] E_K        = -770;
    localparam logic signed [DW-1:0] E_L        = -544;

    localparam logic signed [DW-1:0] S16_MAX = 32767;
    localparam logic signed [DW-1:0] S16_MIN = -32768;

    typedef enum logic [1:0] {IDLE, CALC, HOLD} hh_state_e;

    function automatic logic signed [DW-1:0] sx16(input logic signed [15:0] x);
        return {{(DW-16){x[15]}}, x};
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [DW-1:0] x);
        return (x > S16_MAX) ? 16'h7fff : (x < S16_MIN) ? 16'h8000 : x[15:0];
    endfunction

endpackage

// File: rtl/hh_membrane_integrator_if.sv
// hh_membrane_integrator_if: sample-in / result-out handshake bundle
interface hh_membrane_integrator_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] m_in;
    logic signed [15:0] h_in;
    logic signed [15:0] n_in;
    logic signed [15:0] i_ext;
    logic        [15:0] dt;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] v_out;
    logic               spike;

    modport master (
        output in_valid, m_in, h_in, n_in, i_ext, dt, out_ready,
        input  in_ready, out_valid, v_out, spike
    );

    modport slave (
        input  in_valid, m_in, h_in, n_in, i_ext, dt, out_ready,
        output in_ready, out_valid, v_out, spike
    );
endinterface

// File: rtl/hh_mul_div1000.sv
// hh_mul_div1000: shared signed multiplier followed by truncating divide by the gate scale
module hh_mul_div1000
    import hh_pkg::*;
(
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    output logic signed [DW-1:0] p_o
);

    localparam logic signed [2*DW-1:0] K = {{DW{1'b0}}, GATE_SCALE};

    logic signed [2*DW-1:0] prod;

    assign prod = $signed({{DW{a_i[DW-1]}}, a_i}) * $signed({{DW{b_i[DW-1]}}, b_i});
    assign p_o  = DW'(prod / K);

endmodule

// File: rtl/hh_membrane_integrator.sv
// hh_membrane_integrator: one Hodgkin-Huxley membrane update per accepted sample, ten
// sequential steps on a single shared multiply/divide unit.
// Optional HH_SPIKE_DETECT_EN: flags an upward crossing of SPIKE_THRESH; absent, spike is tied low.
module hh_membrane_integrator
    import hh_pkg::*;
#(
    parameter logic signed [15:0] V_REST       = -16'sd650,
    parameter logic signed [15:0] SPIKE_THRESH = 16'sd0
) (
    input  logic clk,
    input  logic reset,
    hh_membrane_integrator_if.slave bus
);

    hh_state_e          state_q;
    logic [3:0]         cnt_q;
    logic signed [15:0] m_q, h_q, n_q, iext_q, v_q;
    logic        [15:0] dt_q;
    logic signed [DW-1:0] x_q, a_q, b_q, sum_q, dv_q;
    logic               rdy_q, ov_q;
    logic signed [DW-1:0] op_a, op_b, prod, v_ext;
    logic signed [15:0] v_new;

    assign v_ext = sx16(v_q);
    assign v_new = sat16(v_ext + dv_q);

    // step-indexed operand select for the shared multiplier
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (cnt_q)
            4'd1: begin op_a = sx16(m_q);                  op_b = sx16(m_q);   end
            4'd2: begin op_a = x_q;                        op_b = sx16(m_q);   end
            4'd3: begin op_a = x_q;                        op_b = sx16(h_q);   end
            4'd4: begin op_a = sx16(n_q);                  op_b = sx16(n_q);   end
            4'd5: begin op_a = x_q;                        op_b = x_q;         end
            4'd6: begin op_a = G_NA * a_q;                 op_b = v_ext - E_NA; end
            4'd7: begin op_a = G_K * b_q;                  op_b = v_ext - E_K;  end
            4'd8: begin op_a = G_L_X10 * (GATE_SCALE / 10); op_b = v_ext - E_L; end
            4'd9: begin op_a = sum_q;                      op_b = {{(DW-16){1'b0}}, dt_q}; end
            default: ;
        endcase
    end

    hh_mul_div1000 u_mul (
        .a_i (op_a),
        .b_i (op_b),
        .p_o (prod)
    );

    // control FSM and datapath: capture, ten compute steps, hold result until taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            {m_q, h_q, n_q, iext_q, dt_q} <= '0;
            {x_q, a_q, b_q, sum_q, dv_q}  <= '0;
            v_q     <= V_REST;
            rdy_q   <= 1'b1;
            ov_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid && rdy_q) begin
                    state_q <= CALC;
                    rdy_q   <= 1'b0;
                    cnt_q   <= 4'd1;
                    m_q     <= bus.m_in;
                    h_q     <= bus.h_in;
                    n_q     <= bus.n_in;
                    iext_q  <= bus.i_ext;
                    dt_q    <= bus.dt;
                end
                CALC: begin
                    cnt_q <= cnt_q + 4'd1;
                    case (cnt_q)
                        4'd1, 4'd2, 4'd4: x_q   <= prod;
                        4'd3:             a_q   <= prod;
                        4'd5:             b_q   <= prod;
                        4'd6:             sum_q <= sx16(iext_q) - prod;
                        4'd7, 4'd8:       sum_q <= sum_q - prod;
                        4'd9:             dv_q  <= prod;
                        4'd10:            v_q   <= v_new;
                        4'd11: begin
                            state_q <= HOLD;
                            ov_q    <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                HOLD: if (bus.out_ready) begin
                    state_q <= IDLE;
                    ov_q    <= 1'b0;
                    rdy_q   <= 1'b1;
                    cnt_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = ov_q;
    assign bus.v_out     = v_q;

`ifdef HH_SPIKE_DETECT_EN
    logic pre_q, spike_q;

    // crossing is judged at the v update, published together with out_valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q   <= 1'b0;
            spike_q <= 1'b0;
        end else if (state_q == CALC && cnt_q == 4'd10) begin
            pre_q <= (v_q < SPIKE_THRESH) && (v_new >= SPIKE_THRESH);
        end else if (state_q == CALC && cnt_q == 4'd11) begin
            spike_q <= pre_q;
        end else if (state_q == HOLD && bus.out_ready) begin
            spike_q <= 1'b0;
        end
    end

    assign bus.spike = spike_q;
`else
    assign bus.spike = 1'b0;
`endif

endmodule

// File: tb/tb_hh_membrane_integrator.sv
// tb_hh_membrane_integrator: directed and randomized samples checked against an arithmetic HH model
module tb_hh_membrane_integrator;

    localparam int VR = -650;
    localparam int TH = -600;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    longint v_m;

    always #5 clk = ~clk;

    hh_membrane_integrator_if bus();

    hh_membrane_integrator #(.SPIKE_THRESH(-16'sd600)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model(input longint v, m, h, n, ie, dt, output longint vn, output logic sp);
        longint a, b, ina, ik, il, dv;
        a   = ((m * m / 1000) * m / 1000) * h / 1000;
        b   = (n * n / 1000) * (n * n / 1000) / 1000;
        ina = 120 * a * (v - 500) / 1000;
        ik  = 36 * b * (v + 770) / 1000;
        il  = 3 * (v + 544) / 10;
        dv  = (ie - ina - ik - il) * dt / 1000;
        vn  = v + dv;
        if (vn > 32767)  vn = 32767;
        if (vn < -32768) vn = -32768;
`ifdef HH_SPIKE_DETECT_EN
        sp = (v < TH) && (vn >= TH);
`else
        sp = 1'b0;
`endif
    endfunction

    task automatic do_sample(input int m, h, n, ie, dt, input int stall);
        int lat;
        longint vn;
        logic sp;
        @(negedge clk);
        chk("idle_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.m_in = 16'(m);
        bus.h_in = 16'(h);
        bus.n_in = 16'(n);
        bus.i_ext = 16'(ie);
        bus.dt = 16'(dt);
        @(negedge clk);
        model(v_m, m, h, n, ie, dt, vn, sp);
        v_m = vn;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            bus.in_valid = 1'($urandom);
            bus.m_in = 16'($urandom);
            bus.i_ext = 16'($urandom);
            bus.dt = 16'($urandom);
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        chk("latency", lat, 11);
        chk("v_out", bus.v_out, vn);
        chk("spike", bus.spike, sp);
        chk("busy_ready", bus.in_ready, 0);
        repeat (stall) begin
            bus.in_valid = 1'($urandom);
            @(negedge clk);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_v", bus.v_out, vn);
            chk("hold_spike", bus.spike, sp);
            chk("hold_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("post_valid", bus.out_valid, 0);
        chk("post_ready", bus.in_ready, 1);
    endtask

    task automatic abort_at(input int k);
        int stray;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.m_in = 16'sd500;
        bus.h_in = 16'sd500;
        bus.n_in = 16'sd500;
        bus.i_ext = 16'sd2000;
        bus.dt = 16'd50;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (k) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_v", bus.v_out, VR);
        reset = 1'b0;
        v_m = VR;
        stray = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        chk("abort_quiet", stray, 0);
        chk("abort_ready", bus.in_ready, 1);
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.m_in = '0;
        bus.h_in = '0;
        bus.n_in = '0;
        bus.i_ext = '0;
        bus.dt = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_v", bus.v_out, VR);
        chk("rst_spike", bus.spike, 0);
        v_m = VR;
        do_sample(53, 596, 318, 0, 10, 0);
        do_sample(0, 0, 0, 1000, 100, 0);
        abort_at(4);
        repeat (3) do_sample(0, 0, 0, 32767, 65535, 0);
        do_sample(300, 400, 500, -1500, 20, 20);
        abort_at(4);
        abort_at(int'($urandom_range(9)));
        repeat (25)
            do_sample($urandom_range(1100), $urandom_range(1000), $urandom_range(1000),
                      int'($urandom_range(4000)) - 2000, $urandom_range(30), $urandom_range(3));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
